// File: rtl/sequenciador_andar_pkg.sv
// Shared definitions for the floor sequencer: state codes (also decoded by the
// seven-segment debug display), signal widths and a width helper.
package sequenciador_andar_pkg;

    localparam int ANDAR_W  = 2;
    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] EST_INICIAL        = 4'd0;
    localparam logic [ESTADO_W-1:0] EST_DISPARA        = 4'd1;
    localparam logic [ESTADO_W-1:0] EST_AGUARDA_PRONTO = 4'd2;
    localparam logic [ESTADO_W-1:0] EST_ATRASO         = 4'd3;
    localparam logic [ESTADO_W-1:0] EST_AVALIA         = 4'd4;
    localparam logic [ESTADO_W-1:0] EST_FALHA          = 4'd5;
    localparam logic [ESTADO_W-1:0] EST_ESPERA_PERIODO = 4'd6;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL        = EST_INICIAL,
        DISPARA        = EST_DISPARA,
        AGUARDA_PRONTO = EST_AGUARDA_PRONTO,
        ATRASO         = EST_ATRASO,
        AVALIA         = EST_AVALIA,
        FALHA          = EST_FALHA,
        ESPERA_PERIODO = EST_ESPERA_PERIODO
    } estado_t;

    // Bits needed to hold values 0..m-1, never less than one bit.
    function automatic int largura(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sequenciador_andar_if.sv
// Sensor-side handshake plus the results handed to the elevator control unit.
interface sequenciador_andar_if;
    import sequenciador_andar_pkg::*;

    logic                habilitar;
    logic                pronto;
    logic [ANDAR_W-1:0]  andar_medido;
    logic                medir;
    logic [ANDAR_W-1:0]  andar_atual;
    logic                andar_valido;
    logic                mudou_andar;
    logic                erro_sensor;
    logic [ESTADO_W-1:0] db_estado;

    modport slave (
        input  habilitar, pronto, andar_medido,
        output medir, andar_atual, andar_valido, mudou_andar, erro_sensor, db_estado
    );

    modport master (
        output habilitar, pronto, andar_medido,
        input  medir, andar_atual, andar_valido, mudou_andar, erro_sensor, db_estado
    );

endinterface

// File: rtl/sequenciador_andar_contador_limite.sv
// Up-counter over 0..M-1 with synchronous clear and enable. It stops at M-1
// instead of wrapping, and flags that terminal value.
module contador_limite
    import sequenciador_andar_pkg::*;
#(
    parameter int M = 4,
    localparam int W = largura(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpar,
    input  logic         habilitar,
    output logic [W-1:0] contagem,
    output logic         fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] cnt_r;

    // Count register: clear wins over enable, saturates at the terminal value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r <= {W{1'b0}};
        end else if (limpar) begin
            cnt_r <= {W{1'b0}};
        end else if (habilitar && (cnt_r != ULTIMO)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign contagem = cnt_r;
    assign fim      = (cnt_r == ULTIMO);

endmodule

// File: rtl/sequenciador_andar.sv
// Floor sequencer: triggers periodic ultrasonic measurements, supervises the
// reply with a timeout, and confirms the floor code over several agreeing
// readings before publishing it to the elevator control unit.
module sequenciador_andar
    import sequenciador_andar_pkg::*;
#(
    parameter int PERIODO_MEDIDA = 5_000_000,
    parameter int TIMEOUT        = 2_500_000,
    parameter int ATRASO_AMOSTRA = 2,
    parameter int N_CONFIRMA     = 3,
    parameter int MAX_FALHAS     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    sequenciador_andar_if.slave  bus
);

    localparam int PW = largura(PERIODO_MEDIDA);
    localparam int TW = largura(TIMEOUT);
    localparam int CW = largura(N_CONFIRMA + 1);
    localparam int FW = largura(MAX_FALHAS + 1);

    localparam logic [CW-1:0] CONTA_MAX  = CW'(N_CONFIRMA);
    localparam logic [FW-1:0] FALHAS_MAX = FW'(MAX_FALHAS);
    // The timeout timer doubles as the sampling-delay timer, so the delay is
    // assumed shorter than the timeout.
    localparam logic [TW-1:0] ATRASO_FIM = TW'((ATRASO_AMOSTRA > 0) ? ATRASO_AMOSTRA - 1 : 0);
    localparam bit            SEM_ATRASO = (ATRASO_AMOSTRA == 0);

    estado_t              estado_r, prox_estado_s;

    logic [PW-1:0]        per_cnt_unused_s;   // only the terminal flag matters
    logic                 per_fim_s, per_clr_s, per_en_s;
    logic [TW-1:0]        tmo_cnt_s;
    logic                 tmo_fim_s, tmo_en_s, tmo_pronto_clr_s, tmo_clr_s;

    logic [ANDAR_W-1:0]   candidato_r, candidato_s;
    logic [CW-1:0]        conta_r, conta_s;
    logic [FW-1:0]        falhas_r, falhas_s;
    logic                 erro_r, erro_s;
    logic                 valido_r, valido_s;
    logic [ANDAR_W-1:0]   atual_r, atual_s;
    logic                 mudou_r, mudou_s;
    logic                 medir_r;

    // Start-to-start period timer.
    contador_limite #(.M(PERIODO_MEDIDA)) u_periodo (
        .clock     (clock),
        .reset     (reset),
        .limpar    (per_clr_s),
        .habilitar (per_en_s),
        .contagem  (per_cnt_unused_s),
        .fim       (per_fim_s)
    );

    // Reply timeout, reused afterwards to time the sampling delay.
    contador_limite #(.M(TIMEOUT)) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .limpar    (tmo_clr_s),
        .habilitar (tmo_en_s),
        .contagem  (tmo_cnt_s),
        .fim       (tmo_fim_s)
    );

    // Next-state, timer control and next values of the floor-tracking registers.
    always_comb begin
        prox_estado_s    = estado_r;
        tmo_en_s         = 1'b0;
        tmo_pronto_clr_s = 1'b0;
        tmo_clr_s        = 1'b0;
        per_en_s         = 1'b0;
        per_clr_s        = 1'b0;
        candidato_s      = candidato_r;
        conta_s          = conta_r;
        falhas_s         = falhas_r;
        erro_s           = erro_r;
        valido_s         = valido_r;
        atual_s          = atual_r;
        mudou_s          = 1'b0;

        case (estado_r)
            INICIAL: begin
                if (bus.habilitar) prox_estado_s = DISPARA;
                else               prox_estado_s = INICIAL;
            end
            DISPARA: begin
                tmo_en_s      = 1'b1;
                prox_estado_s = AGUARDA_PRONTO;
            end
            AGUARDA_PRONTO: begin
                // A reply on the very timeout cycle still counts as success.
                if (bus.pronto) begin
                    tmo_pronto_clr_s = 1'b1;
                    if (SEM_ATRASO) prox_estado_s = AVALIA;
                    else            prox_estado_s = ATRASO;
                end else if (tmo_fim_s) begin
                    prox_estado_s = FALHA;
                end else begin
                    tmo_en_s      = 1'b1;
                    prox_estado_s = AGUARDA_PRONTO;
                end
            end
            ATRASO: begin
                if (tmo_cnt_s == ATRASO_FIM) begin
                    prox_estado_s = AVALIA;
                end else begin
                    tmo_en_s      = 1'b1;
                    prox_estado_s = ATRASO;
                end
            end
            AVALIA: begin
                candidato_s = bus.andar_medido;
                if (bus.andar_medido == candidato_r) begin
                    if (conta_r == CONTA_MAX) conta_s = conta_r;
                    else                      conta_s = conta_r + CW'(1);
                end else begin
                    conta_s = CW'(1);
                end
                falhas_s = FW'(0);
                erro_s   = 1'b0;
                // Publish only on confirmation of a new floor, or when recovering validity.
                if ((conta_s == CONTA_MAX) && (!valido_r || (bus.andar_medido != atual_r))) begin
                    atual_s  = bus.andar_medido;
                    valido_s = 1'b1;
                    mudou_s  = 1'b1;
                end else begin
                    atual_s  = atual_r;
                    valido_s = valido_r;
                    mudou_s  = 1'b0;
                end
                prox_estado_s = ESPERA_PERIODO;
            end
            FALHA: begin
                if (falhas_r == FALHAS_MAX) falhas_s = falhas_r;
                else                        falhas_s = falhas_r + FW'(1);
                if (falhas_s == FALHAS_MAX) begin
                    erro_s   = 1'b1;
                    valido_s = 1'b0;
                    conta_s  = CW'(0);
                end else begin
                    erro_s   = erro_r;
                    valido_s = valido_r;
                    conta_s  = conta_r;
                end
                prox_estado_s = ESPERA_PERIODO;
            end
            ESPERA_PERIODO: begin
                if (per_fim_s) begin
                    if (bus.habilitar) prox_estado_s = DISPARA;
                    else               prox_estado_s = INICIAL;
                end else begin
                    prox_estado_s = ESPERA_PERIODO;
                end
            end
            default: begin
                prox_estado_s = INICIAL;
            end
        endcase

        // Both timers restart as DISPARA is entered, so they read 0 during it.
        per_en_s  = (estado_r != INICIAL);
        per_clr_s = (prox_estado_s == DISPARA);
        tmo_clr_s = tmo_pronto_clr_s | per_clr_s;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= prox_estado_s;
        end
    end

    // Floor-tracking registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            candidato_r <= {ANDAR_W{1'b0}};
            conta_r     <= {CW{1'b0}};
            falhas_r    <= {FW{1'b0}};
            erro_r      <= 1'b0;
            valido_r    <= 1'b0;
            atual_r     <= {ANDAR_W{1'b0}};
            mudou_r     <= 1'b0;
            medir_r     <= 1'b0;
        end else begin
            candidato_r <= candidato_s;
            conta_r     <= conta_s;
            falhas_r    <= falhas_s;
            erro_r      <= erro_s;
            valido_r    <= valido_s;
            atual_r     <= atual_s;
            mudou_r     <= mudou_s;
            medir_r     <= (prox_estado_s == DISPARA);
        end
    end

    assign bus.medir        = medir_r;
    assign bus.andar_atual  = atual_r;
    assign bus.andar_valido = valido_r;
    assign bus.mudou_andar  = mudou_r;
    assign bus.erro_sensor  = erro_r;
    assign bus.db_estado    = estado_r;

endmodule

// File: tb/tb_sequenciador_andar.sv
// Directed bench for sequenciador_andar: expected per-measurement results are
// queued when a reading is driven and popped once the sequencer has evaluated it.
module tb_sequenciador_andar;

    logic clock = 1'b0;
    logic reset;

    sequenciador_andar_if bus();

    sequenciador_andar #(
        .PERIODO_MEDIDA (40),
        .TIMEOUT        (20),
        .ATRASO_AMOSTRA (2),
        .N_CONFIRMA     (3),
        .MAX_FALHAS     (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    // Count change pulses and any back-to-back pulse.
    int n_pulsos = 0;
    int n_duplos = 0;
    bit mudou_ant = 1'b0;
    always @(negedge clock) begin
        if (bus.mudou_andar === 1'b1) n_pulsos++;
        if ((bus.mudou_andar === 1'b1) && mudou_ant) n_duplos++;
        mudou_ant = (bus.mudou_andar === 1'b1);
    end

    typedef struct packed {
        logic [1:0] atual;
        logic       valido;
        logic       mudou;
        logic       erro;
    } esperado_t;

    esperado_t fila[$];
    int ultimo_medir = -1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        assert (obs === esp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, esp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic esperar_medir(input string tag, output int c0);
        int n;
        n = 0;
        while ((bus.medir !== 1'b1) && (n < 60)) begin
            tick();
            n++;
        end
        chk({tag, "_medir"}, 32'(bus.medir === 1'b1), 32'd1);
        c0 = cyc;
    endtask

    // One measurement cycle: k_pronto < 0 means no reply, k_desliga >= 0 drops
    // habilitar that many cycles after medir.
    task automatic medida(input string tag, input int k_pronto, input logic [1:0] valor,
                          input bit chk_periodo, input int k_desliga,
                          input logic [1:0] e_atual, input logic e_valido,
                          input logic e_mudou, input logic e_erro);
        int c0, n, i;
        esperado_t e, r;
        esperar_medir(tag, c0);
        if (chk_periodo) chk({tag, "_periodo"}, 32'(c0 - ultimo_medir), 32'd40);
        ultimo_medir = c0;
        e.atual = e_atual; e.valido = e_valido; e.mudou = e_mudou; e.erro = e_erro;
        fila.push_back(e);
        bus.andar_medido = valor;
        tick();
        chk({tag, "_medir_1ciclo"}, 32'(bus.medir), 32'd0);
        n = 0;
        while (n < 60) begin
            i = cyc - c0;
            bus.pronto = (i == k_pronto);
            if (i == k_desliga) bus.habilitar = 1'b0;
            if ((bus.db_estado == 4'd4) || (bus.db_estado == 4'd5)) break;
            tick();
            n++;
        end
        bus.pronto = 1'b0;
        if (k_pronto >= 0) begin
            chk({tag, "_avalia"}, 32'(bus.db_estado), 32'd4);
            chk({tag, "_t_avalia"}, 32'(cyc - c0), 32'(k_pronto + 3));
        end else begin
            chk({tag, "_falha"}, 32'(bus.db_estado), 32'd5);
            chk({tag, "_t_falha"}, 32'(cyc - c0), 32'd20);
        end
        tick();
        r = fila.pop_front();
        chk({tag, "_atual"},  32'(bus.andar_atual),  32'(r.atual));
        chk({tag, "_valido"}, 32'(bus.andar_valido), 32'(r.valido));
        chk({tag, "_mudou"},  32'(bus.mudou_andar),  32'(r.mudou));
        chk({tag, "_erro"},   32'(bus.erro_sensor),  32'(r.erro));
        chk({tag, "_espera"}, 32'(bus.db_estado),    32'd6);
        tick();
        chk({tag, "_mudou_fim"}, 32'(bus.mudou_andar), 32'd0);
    endtask

    initial begin
        int c0, c_rel, n, n_med;
        reset            = 1'b0;
        bus.habilitar    = 1'b0;
        bus.pronto       = 1'b0;
        bus.andar_medido = 2'd0;
        repeat (3) tick();

        // 1. Reset state, then start.
        chk("rst_medir",  32'(bus.medir),        32'd0);
        chk("rst_atual",  32'(bus.andar_atual),  32'd0);
        chk("rst_valido", 32'(bus.andar_valido), 32'd0);
        chk("rst_mudou",  32'(bus.mudou_andar),  32'd0);
        chk("rst_erro",   32'(bus.erro_sensor),  32'd0);
        chk("rst_estado", 32'(bus.db_estado),    32'd0);
        reset         = 1'b1;
        bus.habilitar = 1'b1;
        c_rel         = cyc;

        // 2. Confirmation of floor 2.
        medida("m1", 5, 2'd2, 1'b0, -1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("m1_latencia", 32'(ultimo_medir - c_rel), 32'd1);
        medida("m2", 5, 2'd2, 1'b1, -1, 2'd0, 1'b0, 1'b0, 1'b0);
        medida("m3", 5, 2'd2, 1'b1, -1, 2'd2, 1'b1, 1'b1, 1'b0);

        // 3. Glitch rejection, then move to floor 1.
        medida("g1", 5, 2'd2, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("g2", 5, 2'd3, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("g3", 5, 2'd2, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("g4", 5, 2'd2, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("g5", 5, 2'd2, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("u1", 5, 2'd1, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("u2", 5, 2'd1, 1'b1, -1, 2'd2, 1'b1, 1'b0, 1'b0);
        medida("u3", 5, 2'd1, 1'b1, -1, 2'd1, 1'b1, 1'b1, 1'b0);

        // 4. Timeouts, sensor fault and recovery.
        medida("f1", -1, 2'd1, 1'b1, -1, 2'd1, 1'b1, 1'b0, 1'b0);
        medida("f2", -1, 2'd1, 1'b1, -1, 2'd1, 1'b0, 1'b0, 1'b1);
        medida("r1", 5, 2'd1, 1'b1, -1, 2'd1, 1'b0, 1'b0, 1'b0);
        medida("r2", 5, 2'd1, 1'b1, -1, 2'd1, 1'b0, 1'b0, 1'b0);
        medida("r3", 5, 2'd1, 1'b1, -1, 2'd1, 1'b1, 1'b1, 1'b0);

        // 5. Reply on the timeout cycle, then a stray reply while waiting.
        medida("s1", 19, 2'd1, 1'b1, -1, 2'd1, 1'b1, 1'b0, 1'b0);
        bus.pronto = 1'b1;
        tick();
        bus.pronto = 1'b0;
        chk("stray_estado1", 32'(bus.db_estado), 32'd6);
        tick();
        chk("stray_estado2", 32'(bus.db_estado), 32'd6);

        // 6a. Drop habilitar while awaiting the reply.
        medida("d1", 5, 2'd1, 1'b1, 3, 2'd1, 1'b1, 1'b0, 1'b0);
        n = 0;
        while ((bus.db_estado !== 4'd0) && (n < 60)) begin
            tick();
            n++;
        end
        chk("d1_inicial",   32'(bus.db_estado), 32'd0);
        chk("d1_t_inicial", 32'(cyc - ultimo_medir), 32'd40);
        n_med = 0;
        repeat (60) begin
            tick();
            if (bus.medir === 1'b1) n_med++;
        end
        chk("d1_sem_medir", 32'(n_med), 32'd0);
        chk("d1_atual",  32'(bus.andar_atual),  32'd1);
        chk("d1_valido", 32'(bus.andar_valido), 32'd1);

        // 6b. Reset during the sampling delay.
        bus.habilitar = 1'b1;
        esperar_medir("x1", c0);
        n = 0;
        while ((bus.db_estado !== 4'd3) && (n < 30)) begin
            bus.pronto = ((cyc - c0) == 5);
            tick();
            n++;
        end
        bus.pronto = 1'b0;
        chk("x1_atraso",   32'(bus.db_estado), 32'd3);
        chk("x1_t_atraso", 32'(cyc - c0), 32'd6);
        reset = 1'b0;
        tick();
        chk("x1_estado", 32'(bus.db_estado),    32'd0);
        chk("x1_medir",  32'(bus.medir),        32'd0);
        chk("x1_atual",  32'(bus.andar_atual),  32'd0);
        chk("x1_valido", 32'(bus.andar_valido), 32'd0);
        chk("x1_mudou",  32'(bus.mudou_andar),  32'd0);
        chk("x1_erro",   32'(bus.erro_sensor),  32'd0);
        bus.pronto = 1'b1;
        tick();
        reset         = 1'b1;
        bus.habilitar = 1'b0;
        tick();
        bus.pronto = 1'b0;
        chk("x1_pronto_ignorado", 32'(bus.db_estado), 32'd0);
        chk("x1_pronto_medir",    32'(bus.medir),     32'd0);
        tick();

        chk("fila_vazia",   32'(fila.size()), 32'd0);
        chk("total_pulsos", 32'(n_pulsos),    32'd3);
        chk("pulsos_duplos", 32'(n_duplos),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
